eth_tx_sequencer: RTL and testbench
===================================

ETH_TX_SEQUENCER -- requirements
Module: eth_tx_sequencer

Interface
REQ-001 PARAM FRAME_BYTES, default 64, meaning: frame bytes fetched after SFD (MAC+IP+UDP headers, payload, FCS); range 46..255.
REQ-002 PARAM NLP_PERIOD, default 320000, meaning: idle cycles between link pulses (16 ms at 20 MHz).
REQ-003 PARAM IFG_CYCLES, default 192, meaning: inter-frame gap (9.6 us).
REQ-004 i_clk  in  1  20 MHz clock, the block's only clock.
REQ-005 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_start  in  1  send request pulse from the packet-rate counter.
REQ-007 i_byte  in  8  frame byte returned by the header/payload source one cycle after o_rd_en.
REQ-008 o_rd_en  out  1  one-cycle byte fetch strobe.
REQ-009 o_rd_addr  out  8  byte index 0..FRAME_BYTES-1, valid with o_rd_en.
REQ-010 o_pos, o_neg  out  1 each  differential line drive.
REQ-011 o_busy  out  1  high in every state except IDLE and NLP.
REQ-012 o_frame_done  out  1  one-cycle pulse on the last ETD cycle.

Function
REQ-013 States SHALL be IDLE, NLP, PREAMBLE, DATA, ETD, IFG.
REQ-014 Bit time SHALL be 2 cycles; byte slot SHALL be 16 cycles (slot cycles 0..15); bits SHALL be sent LSB first.
REQ-015 Manchester, active states PREAMBLE/DATA: bit 0 -> o_pos 1 then 0; bit 1 -> o_pos 0 then 1; o_neg SHALL equal ~o_pos.
REQ-016 PREAMBLE SHALL send 7 bytes 0x55 then SFD 0xD5, generated internally (8 slots, 128 cycles).
REQ-017 DATA SHALL send FRAME_BYTES slots; byte k SHALL be fetched with o_rd_en=1, o_rd_addr=k on slot cycle 14 of the preceding slot (SFD slot for k=0), i_byte sampled on cycle 15, shifted from cycle 0 of the next slot.
REQ-018 o_rd_en SHALL pulse exactly FRAME_BYTES times per frame, addresses strictly ascending from 0; never outside PREAMBLE/DATA.
REQ-019 ETD: o_pos=1, o_neg=0 for 6 cycles; o_frame_done on the 6th; then IFG.
REQ-020 IFG: o_pos=o_neg=0 for IFG_CYCLES cycles, then PREAMBLE if pending set (pending cleared), else IDLE.
REQ-021 IDLE: o_pos=o_neg=0; NLP counter increments each cycle in IDLE; on reaching NLP_PERIOD-1 enter NLP, counter cleared.
REQ-022 NLP: o_pos=1, o_neg=0 for exactly 2 cycles, then IDLE.
REQ-023 NLP counter SHALL clear on entering PREAMBLE; first NLP after a frame occurs NLP_PERIOD IDLE cycles after IFG ends.
REQ-024 i_start in IDLE at cycle T: PREAMBLE from T+1 (first line half-bit at T+1), o_busy=1 at T+1; NLP counter expiry on same cycle loses to i_start.
REQ-025 i_start in any other state SHALL set a one-deep pending flag; multiple requests collapse to one; pending set in NLP SHALL start PREAMBLE on the cycle after NLP ends.
REQ-026 Frame length start-to-IDLE: (8+FRAME_BYTES)*16 + 6 + IFG_CYCLES cycles (1350 at defaults).

Reset
REQ-027 i_rst_n low SHALL immediately (no clock): state IDLE, o_pos=o_neg=0, o_rd_en=0, o_rd_addr=0, o_busy=0, o_frame_done=0, pending=0, NLP/bit/byte counters 0.
REQ-028 Reset mid-frame SHALL abort with no further o_rd_en; after release, block behaves as from power-up.
REQ-029 Release SHALL be sampled on i_clk; first active cycle is the first edge with i_rst_n high.

Verification
REQ-030 Idle after reset, no i_start -> NLP 2-cycle pulse on o_pos at cycle 320000, repeating every 320002 cycles; o_busy stays 0.
REQ-031 Single i_start, i_byte = o_rd_addr -> 64 o_rd_en at addresses 0..63, decoded line = 7x0x55, 0xD5, 0x00..0x3F; 6-cycle ETD; o_frame_done once; o_busy 0 exactly 1350 cycles after start.
REQ-032 Three i_start pulses during DATA -> exactly one extra frame, its PREAMBLE beginning the cycle after IFG ends.
REQ-033 i_start coincident with NLP second cycle -> NLP completes full 2 cycles, PREAMBLE next cycle.
REQ-034 Async reset pulsed at slot cycle 7 of byte 20 -> o_pos/o_neg 0 before next edge, no o_rd_en afterwards; new i_start yields full frame from address 0.
REQ-035 i_byte=0xA5 at address 14 -> line half-bit pairs for that slot: 01,10,01,10,10,01,10,01.

Source files
------------

// File: rtl/eth_tx_sequencer.sv
// eth_tx_sequencer: 10BASE-T style Manchester transmitter.
// Sends preamble/SFD and fetched frame bytes, ETD and IFG, and emits link pulses while idle.
module eth_tx_sequencer #(
  parameter int FRAME_BYTES = 64,
  parameter int NLP_PERIOD  = 320000,
  parameter int IFG_CYCLES  = 192
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_rd_en,
  output logic [7:0] o_rd_addr,
  output logic       o_pos,
  output logic       o_neg,
  output logic       o_busy,
  output logic       o_frame_done
);
  typedef enum logic [2:0] {IDLE, NLP, PREAMBLE, DATA, ETD, IFG} state_e;
  localparam int NW = $clog2(NLP_PERIOD + 1);
  localparam int CW = $clog2(IFG_CYCLES + 6);
  state_e        state_q, state_d;
  logic [3:0]    cyc_q, cyc_d;
  logic [7:0]    idx_q, idx_d, byte_q, byte_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] nlp_q, nlp_d;
  logic          pend_q, pend_d;
  logic          active, slot_end, req, line;
  logic [7:0]    cur_byte;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      cnt_q   <= '0;
      nlp_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      nlp_q   <= nlp_d;
      pend_q  <= pend_d;
    end
  end
  // Slot index counts 0..7 in PREAMBLE and 0..FRAME_BYTES-1 in DATA; the next byte is fetched on cycle 14.
  always_comb begin
    active       = state_q == PREAMBLE || state_q == DATA;
    slot_end     = active && cyc_q == 4'd15;
    req          = pend_q | i_start;
    cur_byte     = state_q == PREAMBLE ? (idx_q == 8'd7 ? 8'hD5 : 8'h55) : byte_q;
    line         = ~(cyc_q[0] ^ cur_byte[cyc_q[3:1]]);
    o_rd_en      = active && cyc_q == 4'd14 &&
                   (state_q == PREAMBLE ? idx_q == 8'd7 : idx_q != 8'(FRAME_BYTES - 1));
    o_rd_addr    = o_rd_en ? (state_q == PREAMBLE ? 8'd0 : idx_q + 8'd1) : 8'd0;
    o_pos        = active ? line : (state_q == NLP || state_q == ETD);
    o_neg        = active & ~line;
    o_busy       = state_q != IDLE && state_q != NLP;
    o_frame_done = state_q == ETD && cnt_q == CW'(5);
    state_d      = state_q;
    cyc_d        = active ? cyc_q + 4'd1 : 4'd0;
    idx_d        = idx_q;
    byte_d       = slot_end ? i_byte : byte_q;
    cnt_d        = cnt_q + 1'b1;
    nlp_d        = nlp_q;
    pend_d       = state_q == IDLE ? 1'b0 : req;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = PREAMBLE;
          idx_d   = '0;
          nlp_d   = '0;
        end else if (nlp_q == NW'(NLP_PERIOD - 1)) begin
          state_d = NLP;
          nlp_d   = '0;
          cnt_d   = '0;
        end else nlp_d = nlp_q + 1'b1;
      end
      NLP: if (cnt_q == CW'(1)) begin
        state_d = req ? PREAMBLE : IDLE;
        pend_d  = 1'b0;
        idx_d   = '0;
      end
      PREAMBLE: if (slot_end) begin
        state_d = idx_q == 8'd7 ? DATA : PREAMBLE;
        idx_d   = idx_q == 8'd7 ? 8'd0 : idx_q + 8'd1;
      end
      DATA: if (slot_end) begin
        state_d = idx_q == 8'(FRAME_BYTES - 1) ? ETD : DATA;
        idx_d   = idx_q + 8'd1;
        cnt_d   = '0;
      end
      ETD: if (cnt_q == CW'(5)) begin
        state_d = IFG;
        cnt_d   = '0;
      end
      IFG: if (cnt_q == CW'(IFG_CYCLES - 1)) begin
        state_d = req ? PREAMBLE : IDLE;
        pend_d  = 1'b0;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_eth_tx_sequencer.sv
// tb_eth_tx_sequencer: random-stimulus bench comparing every cycle against a frame-level reference model.
module tb_eth_tx_sequencer;
  localparam int FB = 64, NP = 1000, IG = 192;
  localparam int FLEN = (8 + FB) * 16 + 6 + IG;
  logic       clk = 1'b0, rst_n, i_start;
  logic [7:0] i_byte, o_rd_addr;
  logic       o_rd_en, o_pos, o_neg, o_busy, o_frame_done;
  eth_tx_sequencer #(.FRAME_BYTES(FB), .NLP_PERIOD(NP), .IFG_CYCLES(IG)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_byte(i_byte),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .o_pos(o_pos), .o_neg(o_neg),
    .o_busy(o_busy), .o_frame_done(o_frame_done)
  );
  always #5 clk = ~clk;
  int          n_cmp, n_err, m_cat, m_idle, m_nlp_left, m_fpos, m_frames;
  int          c_busy, c_done, c_rd, c_nlp, f0;
  bit          m_pend, prev_rd;
  logic [7:0]  prev_addr;
  logic [7:0]  mem [256];
  logic [12:0] cur;
  logic [12:0] m_q [$];
  logic [15:0] w;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  // Expected {busy, done, rd_en, addr, pos, neg} for every cycle of a frame, built from the byte list.
  task automatic start_frame();
    logic [7:0] b;
    m_q.delete();
    for (int j = 0; j < 8 + FB; j++) begin
      b = j < 7 ? 8'h55 : (j == 7 ? 8'hD5 : mem[j-8]);
      for (int c = 0; c < 16; c++) begin
        logic p, rd;
        p  = (c % 2 == 0) ? ~b[c/2] : b[c/2];
        rd = c == 14 && j >= 7 && j < 7 + FB;
        m_q.push_back({1'b1, 1'b0, rd, rd ? 8'(j - 7) : 8'h00, p, ~p});
      end
    end
    for (int i = 0; i < 6; i++) m_q.push_back({1'b1, i == 5, 1'b0, 8'h00, 1'b1, 1'b0});
    for (int i = 0; i < IG; i++) m_q.push_back({1'b1, 12'h000});
    m_cat = 2;
    m_fpos = 0;
    m_frames++;
    cur = m_q.pop_front();
  endtask
  task automatic go_idle();
    m_cat = 0;
    m_idle = 0;
    cur = 13'h0;
  endtask
  task automatic model_step(input logic s);
    if (!rst_n) begin
      m_q.delete();
      m_pend = 0;
      go_idle();
    end else if (m_cat == 2) begin
      if (s) m_pend = 1;
      if (m_q.size() > 0) begin
        cur = m_q.pop_front();
        m_fpos++;
      end else if (m_pend) begin
        m_pend = 0;
        start_frame();
      end else go_idle();
    end else if (m_cat == 1) begin
      if (s) m_pend = 1;
      if (m_nlp_left > 0) m_nlp_left--;
      else if (m_pend) begin
        m_pend = 0;
        start_frame();
      end else go_idle();
    end else if (s) start_frame();
    else if (m_idle == NP - 1) begin
      m_cat = 1;
      m_nlp_left = 1;
      cur = 13'b0_0_0_00000000_1_0;
    end else m_idle++;
  endtask
  task automatic tick(input logic s);
    i_start = s;
    @(posedge clk);
    model_step(s);
    @(negedge clk);
    i_byte = prev_rd ? mem[prev_addr] : 8'($urandom);
    chk("line", {19'h0, o_busy, o_frame_done, o_rd_en, o_rd_en ? o_rd_addr : 8'h00, o_pos, o_neg}, {19'h0, cur});
    c_busy += int'(o_busy);
    c_done += int'(o_frame_done);
    c_rd   += int'(o_rd_en);
    c_nlp  += int'(o_pos && !o_busy);
    if (m_cat == 2 && m_fpos >= 352 && m_fpos < 368) w[m_fpos-352] = o_pos;
    prev_rd = o_rd_en;
    prev_addr = o_rd_addr;
  endtask
  task automatic clr();
    c_busy = 0; c_done = 0; c_rd = 0; c_nlp = 0;
  endtask
  task automatic wait_idle(input int bound);
    int n = 0;
    while ((o_busy || m_cat != 0) && n < bound) begin
      tick(1'b0);
      n++;
    end
    chk("idle_wait", o_busy, 1'b0);
  endtask
  task automatic run_to_fpos(input int p);
    int n = 0;
    while (!(m_cat == 2 && m_fpos == p) && n < 3000) begin
      tick(1'b0);
      n++;
    end
    chk("fpos_wait", n < 3000, 1'b1);
  endtask
  initial begin
    int n;
    n_cmp = 0; n_err = 0; m_frames = 0; m_nlp_left = 0; m_fpos = 0;
    rst_n = 1'b0; i_start = 1'b0; i_byte = 8'h00; prev_rd = 0; prev_addr = 8'h00; w = 16'h0;
    m_pend = 0; go_idle(); clr();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[14] = 8'hA5;
    #1;
    chk("rst_out", {o_busy, o_frame_done, o_rd_en, o_rd_addr, o_pos, o_neg}, 13'h0);
    repeat (3) tick(1'b0);
    rst_n = 1'b1;
    repeat (2 * (NP + 2) + 6) tick(1'b0);
    chk("nlp_cycles", c_nlp, 4);
    chk("idle_busy", c_busy, 0);
    n = 0;
    while (!(m_cat == 0 && m_idle == NP - 1) && n < NP + 10) begin
      tick(1'b0);
      n++;
    end
    chk("expiry_wait", n < NP + 10, 1'b1);
    clr(); w = 16'h0;
    tick(1'b1);
    wait_idle(FLEN + 50);
    chk("frame_busy", c_busy, FLEN);
    chk("frame_done", c_done, 1);
    chk("frame_rd", c_rd, FB);
    chk("a5_line", w, 16'h9966);
    clr();
    tick(1'b1);
    run_to_fpos(128 + 16 * 3);
    tick(1'b1);
    run_to_fpos(128 + 16 * 20);
    tick(1'b1);
    tick(1'b1);
    wait_idle(3 * FLEN);
    chk("pend_busy", c_busy, 2 * FLEN);
    chk("pend_done", c_done, 2);
    chk("pend_rd", c_rd, 2 * FB);
    n = 0;
    while (!(m_cat == 1 && m_nlp_left == 0) && n < NP + 10) begin
      tick(1'b0);
      n++;
    end
    chk("nlp_wait", n < NP + 10, 1'b1);
    tick(1'b1);
    chk("nlp_then_pre", o_busy, 1'b1);
    wait_idle(FLEN + 50);
    for (int i = 0; i < FB; i++) mem[i] = 8'($urandom);
    clr(); f0 = m_frames;
    repeat (6000) tick($urandom_range(0, 249) == 0);
    wait_idle(3 * FLEN);
    chk("rand_done", c_done, m_frames - f0);
    tick(1'b1);
    run_to_fpos((8 + 20) * 16 + 7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pos", o_pos, 1'b0);
    chk("arst_neg", o_neg, 1'b0);
    chk("arst_rd", o_rd_en, 1'b0);
    chk("arst_busy", o_busy, 1'b0);
    repeat (2) tick(1'b0);
    rst_n = 1'b1;
    clr();
    repeat (5) tick(1'b0);
    chk("post_rst_rd", c_rd, 0);
    clr();
    tick(1'b1);
    wait_idle(FLEN + 50);
    chk("post_rst_rd_n", c_rd, FB);
    chk("post_rst_done", c_done, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
